// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode instruction buffer: circular queue taking up to FETCH_W
// instructions per cycle and presenting the oldest FETCH_W in program order.
module inst_fetch_queue #(
  parameter int FETCH_W = 2,
  parameter int XLEN    = 32,
  parameter int DEPTH   = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic [FETCH_W-1:0]           in_valid,
  input  logic [FETCH_W*XLEN-1:0]      in_pc,
  input  logic [FETCH_W*XLEN-1:0]      in_instr,
  output logic                         in_ready,
  output logic [FETCH_W-1:0]           out_valid,
  output logic [FETCH_W*XLEN-1:0]      out_pc,
  output logic [FETCH_W*XLEN-1:0]      out_instr,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Entry storage; contents are never reset, only the pointers and count are.
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];

  logic [PW-1:0] head_reg, head_next;
  logic [PW-1:0] tail_reg, tail_next;
  logic [CW-1:0] count_reg, count_next;
  logic [CW-1:0] free_slots;
  logic [CW-1:0] n_enq, n_deq;
  logic          enq_fire, deq_fire;
  logic [PW-1:0] wr_off [FETCH_W];

  // Readiness looks only at occupancy so fetch never sees a path through decode.
  assign free_slots = CW'(DEPTH) - count_reg;
  assign in_ready   = free_slots >= CW'(FETCH_W);
  assign enq_fire   = in_ready && (|in_valid) && !flush;
  assign deq_fire   = out_ready && (|out_valid) && !flush;
  assign count      = count_reg;

  // Compaction: each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    logic [PW-1:0] acc;
    logic [CW-1:0] cnt;
    acc = '0;
    cnt = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      wr_off[i] = acc;
      acc = acc + PW'(in_valid[i]);
      cnt = cnt + CW'(in_valid[i]);
    end
    n_enq = enq_fire ? cnt : '0;
  end

  always_comb begin
    logic [CW-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      cnt = cnt + CW'(out_valid[i]);
    end
    n_deq = deq_fire ? cnt : '0;
  end

  genvar gi;
  generate
    for (gi = 0; gi < FETCH_W; gi++) begin : g_out_lane
      logic [PW-1:0] rd_ptr;
      assign rd_ptr                       = head_reg + PW'(gi);
      assign out_valid[gi]                = count_reg > CW'(gi);
      assign out_pc[gi*XLEN +: XLEN]      = out_valid[gi] ? pc_mem[rd_ptr]    : '0;
      assign out_instr[gi*XLEN +: XLEN]   = out_valid[gi] ? instr_mem[rd_ptr] : '0;
    end
  endgenerate

  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (flush) begin
      head_next  = '0;
      tail_next  = '0;
      count_next = '0;
    end else begin
      tail_next  = tail_reg + PW'(n_enq);
      head_next  = head_reg + PW'(n_deq);
      count_next = count_reg + n_enq - n_deq;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      for (int i = 0; i < FETCH_W; i++) begin
        if (in_valid[i]) begin
          pc_mem[tail_reg + wr_off[i]]    <= in_pc[i*XLEN +: XLEN];
          instr_mem[tail_reg + wr_off[i]] <= in_instr[i*XLEN +: XLEN];
        end
      end
    end
  end

endmodule
